truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Sequential stimulus driver and checker for the lab's combinational boolean-function modules: it sweeps every input vector, samples two candidate function outputs, and records where they disagree. It is the driving side of a combinational function under test. Its vector output feeds one or two function blocks, and their outputs return on `fa`/`fb`. Results give the captured truth tables, an equivalence verdict, the first mismatching minterm and the mismatch count.

## Interface
- `N`, default 4: number of function inputs; sweep length is 2^N vectors.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; one-cycle pulse or level.
- `dc_mask`  in  2^N  don't-care minterms; bit i set means minterm i is excluded from comparison.
- `fa`  in  1  output of function A for the current `vec_out`; combinational.
- `fb`  in  1  output of function B for the current `vec_out`; combinational.
- `vec_out`  out  N  input vector driven to both functions; MSB is the first literal (a/A).
- `busy`  out  1  high while sweeping.
- `done`  out  1  high from sweep completion until the next accepted `start`.
- `equal`  out  1  1 when no compared minterm mismatched; valid while `done`.
- `mismatch_cnt`  out  N+1  number of mismatching minterms, 0..2^N.
- `mismatch_idx`  out  N  lowest mismatching minterm index; 0 if none.
- `tt_a`, `tt_b`  out  2^N each  captured truth tables; bit i = f(i).

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE or DONE, `start`=1:
  - go to SWEEP;
  - clear `idx`, `mismatch_cnt`, `mismatch_idx`, `tt_a`, `tt_b`, and a first-found flag;
  - `done` drops.
- SWEEP, each cycle:
  - `vec_out = idx`;
  - on the edge, `tt_a[idx] <= fa` and `tt_b[idx] <= fb`;
  - if `fa != fb` and the minterm is not masked: increment `mismatch_cnt`. If this is the first mismatch, latch `mismatch_idx <= idx` and set the found flag.
- SWEEP with `idx == 2^N-1`: after sampling, go to DONE. `idx` wraps to 0, which is never used as a new sample.
- DONE:
  - `equal = (mismatch_cnt == 0)`, registered;
  - outputs hold until the next `start`.
- `start` during SWEEP is ignored; there is no restart mid-sweep.
- `dc_mask` is sampled per minterm during the sweep, so it must be stable for the whole sweep.
- `mismatch_cnt` is N+1 bits and cannot overflow, since its maximum is 2^N.

## Timing
- Reset, asynchronous and active-low, forces:
  - state to IDLE;
  - `vec_out=0`, `busy=0`, `done=0`, `equal=0`;
  - `mismatch_cnt=0`, `mismatch_idx=0`, `tt_a=0`, `tt_b=0`.
- Reset mid-sweep aborts immediately. There is no partial result.
- Cycle 0: `start` sampled. Cycle 1: `busy=1`, `vec_out=0`.
- Cycle k+1 presents `vec_out=k`. The last sample is taken on the edge ending cycle 2^N.
- Cycle 2^N+1: `busy=0`, `done=1`, `equal` valid.
- Latency from `start` to `done` is 2^N+1 cycles.
- `fa`/`fb` must settle within the same cycle as `vec_out`; no pipeline delay is assumed.

## Configuration
- `TTC_DONTCARE_EN` defined: `dc_mask` is honored. Masked minterms are still captured in `tt_a`/`tt_b`, but they never count as mismatches or set `mismatch_idx`.
- `TTC_DONTCARE_EN` undefined: the `dc_mask` port stays present but is ignored, and every minterm is compared.

## Test plan
Use N=3 with `vec_out = {a,b,c}`; f1 = ac'+bc+b'c' has truth table 8'hD9.
- `fa=f1`, `fb=(a+b'+c)(a+b+c')(a'+b+c')`, start -> after 9 cycles: `done=1`, `equal=1`, `mismatch_cnt=0`, `tt_a=tt_b=8'hD9`.
- `fa=f1`, `fb=~f1` -> `equal=0`, `mismatch_cnt=8`, `mismatch_idx=0`, `tt_b=8'h26`.
- `fa=f1`, `fb` = f1 with minterm 5 inverted (`tt_b=8'hF9`) -> `mismatch_cnt=1`, `mismatch_idx=5`.
  - Same stimulus with `dc_mask=8'h20` and `TTC_DONTCARE_EN` defined -> `equal=1`, `mismatch_cnt=0`.
  - Same stimulus with `dc_mask=8'h20` and the macro undefined -> `mismatch_cnt=1`.
- `start` re-pulsed at cycle 4 of a sweep -> ignored; `done` still rises at cycle 9 with results identical to the uninterrupted run.
- `rst_n` low for 1 cycle while `vec_out=3` -> all outputs 0 and `busy=0` immediately. A subsequent `start` completes a normal sweep.

Source files
------------

// File: rtl/truth_table_checker.sv
// Sweeps all 2^N input vectors into two combinational functions, captures both truth
// tables and reports equivalence, mismatch count and lowest mismatching minterm.
// Optional feature: define TTC_DONTCARE_EN to honor dc_mask.
module truth_table_checker #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2**N-1:0]   dc_mask,
    input  logic              fa,
    input  logic              fb,
    output logic [N-1:0]      vec_out,
    output logic              busy,
    output logic              done,
    output logic              equal,
    output logic [N:0]        mismatch_cnt,
    output logic [N-1:0]      mismatch_idx,
    output logic [2**N-1:0]   tt_a,
    output logic [2**N-1:0]   tt_b
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  idx;
    logic          found;
    logic          masked;
    logic          miss;
    logic          last;
    logic [N:0]    cnt_nxt;

`ifdef TTC_DONTCARE_EN
    assign masked = dc_mask[idx];
`else
    logic unused_dc;
    assign unused_dc = ^dc_mask;
    assign masked    = 1'b0;
`endif

    assign miss    = (fa != fb) && !masked;
    assign last    = (idx == {N{1'b1}});
    assign cnt_nxt = miss ? mismatch_cnt + (N+1)'(1) : mismatch_cnt;

    assign vec_out = idx;
    assign busy    = (state == SWEEP);
    assign done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SWEEP;
            SWEEP:      if (last)  state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            found        <= 1'b0;
            equal        <= 1'b0;
            mismatch_cnt <= '0;
            mismatch_idx <= '0;
            tt_a         <= '0;
            tt_b         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx          <= '0;
                        found        <= 1'b0;
                        equal        <= 1'b0;
                        mismatch_cnt <= '0;
                        mismatch_idx <= '0;
                        tt_a         <= '0;
                        tt_b         <= '0;
                    end
                end
                SWEEP: begin
                    tt_a[idx]    <= fa;
                    tt_b[idx]    <= fb;
                    idx          <= idx + N'(1);  // wraps to 0 after the last minterm
                    mismatch_cnt <= cnt_nxt;
                    if (miss && !found) begin
                        mismatch_idx <= idx;
                        found        <= 1'b1;
                    end
                    if (last) equal <= (cnt_nxt == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized + directed bench for truth_table_checker (N=3) against a truth-table model.
module tb_truth_table_checker;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dcm = 8'h00;
    logic [7:0] ta = 8'h00, tb = 8'h00;
    logic       fa, fb;
    logic [2:0] vec_out;
    logic       busy, done, equal;
    logic [3:0] mismatch_cnt;
    logic [2:0] mismatch_idx;
    logic [7:0] tt_a, tt_b;

    int cyc = 0, start_cyc = 0;
    bit started = 0;
    int n_chk = 0, n_pass = 0;
    logic [7:0] exp_ta, exp_tb;
    int exp_cnt, exp_idx;

    assign fa = ta[vec_out];
    assign fb = tb[vec_out];

    truth_table_checker #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dc_mask(dcm), .fa(fa), .fb(fb),
        .vec_out(vec_out), .busy(busy), .done(done), .equal(equal),
        .mismatch_cnt(mismatch_cnt), .mismatch_idx(mismatch_idx), .tt_a(tt_a), .tt_b(tt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic f1(input logic [2:0] v);
        logic a, b, c;
        {a, b, c} = v;
        return (a & ~c) | (b & c) | (~b & ~c);
    endfunction

    function automatic logic f1_pos(input logic [2:0] v);
        logic a, b, c;
        {a, b, c} = v;
        return (a | ~b | c) & (a | b | ~c) & (~a | b | ~c);
    endfunction

    // Expected results straight from the tables: mismatches are differing, uncovered minterms.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                         output int cnt, output int first);
        logic [7:0] diff;
        diff = a ^ b;
`ifdef TTC_DONTCARE_EN
        diff = diff & ~m;
`endif
        cnt = 0;
        first = -1;
        for (int i = 0; i < 8; i++)
            if (diff[i]) begin
                cnt++;
                if (first < 0) first = i;
            end
        if (first < 0) first = 0;
    endtask

    always @(negedge clk) begin
        int k;
        if (!rst_n || !started) begin
            chk("idle_vec", vec_out, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_equal", equal, 0);
            chk("idle_cnt", mismatch_cnt, 0);
            chk("idle_idx", mismatch_idx, 0);
            chk("idle_tta", tt_a, 0);
            chk("idle_ttb", tt_b, 0);
        end else begin
            k = cyc - start_cyc;
            if (k >= 1 && k <= 8) begin
                chk("sw_busy", busy, 1);
                chk("sw_done", done, 0);
                chk("sw_vec", vec_out, k - 1);
            end else if (k >= 9) begin
                chk("dn_busy", busy, 0);
                chk("dn_done", done, 1);
                chk("dn_equal", equal, exp_cnt == 0);
                chk("dn_cnt", mismatch_cnt, exp_cnt);
                chk("dn_idx", mismatch_idx, exp_idx);
                chk("dn_tta", tt_a, exp_ta);
                chk("dn_ttb", tt_b, exp_tb);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        ta = a; tb = b; dcm = m;
        exp_ta = a; exp_tb = b;
        model(a, b, m, exp_cnt, exp_idx);
        start = 1'b1;
        started = 1;
        start_cyc = cyc;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] t1, tpos, tinv, a, b;
        int c0, i0;
        for (int i = 0; i < 8; i++) begin
            t1[i]   = f1(3'(i));
            tpos[i] = f1_pos(3'(i));
        end
        tinv = ~t1;
        chk("pin_f1", t1, 8'hD9);
        chk("pin_pos", tpos, 8'hD9);
        chk("pin_inv", tinv, 8'h26);
        model(8'hD9, 8'hF9, 8'h00, c0, i0);
        chk("pin_model_cnt", c0, 1);
        chk("pin_model_idx", i0, 5);

        step(3);
        rst_n = 1'b1;
        step(2);

        run_sweep(t1, tpos, 8'h00); step(8);
        chk("d1_done", done, 1); chk("d1_equal", equal, 1);
        chk("d1_cnt", mismatch_cnt, 0); chk("d1_tta", tt_a, 8'hD9); chk("d1_ttb", tt_b, 8'hD9);

        run_sweep(t1, tinv, 8'h00); step(8);
        chk("d2_equal", equal, 0); chk("d2_cnt", mismatch_cnt, 8);
        chk("d2_idx", mismatch_idx, 0); chk("d2_ttb", tt_b, 8'h26);

        run_sweep(t1, 8'hF9, 8'h00); step(8);
        chk("d3_cnt", mismatch_cnt, 1); chk("d3_idx", mismatch_idx, 5);

        run_sweep(t1, 8'hF9, 8'h20); step(8);
`ifdef TTC_DONTCARE_EN
        chk("d4_equal", equal, 1); chk("d4_cnt", mismatch_cnt, 0);
`else
        chk("d4_equal", equal, 0); chk("d4_cnt", mismatch_cnt, 1);
`endif
        chk("d4_ttb", tt_b, 8'hF9);

        // start re-pulsed mid-sweep must be ignored
        run_sweep(t1, 8'hF9, 8'h00); step(3);
        start = 1'b1; step(1); start = 1'b0; step(4);
        chk("d5_done", done, 1); chk("d5_cnt", mismatch_cnt, 1); chk("d5_idx", mismatch_idx, 5);

        // reset mid-sweep aborts immediately
        run_sweep(t1, tinv, 8'h00); step(3);
        chk("d6_vec", vec_out, 3);
        rst_n = 1'b0; started = 0;
        #1;
        chk("d6_rst_busy", busy, 0); chk("d6_rst_vec", vec_out, 0); chk("d6_rst_cnt", mismatch_cnt, 0);
        chk("d6_rst_tta", tt_a, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        run_sweep(t1, tinv, 8'h00); step(8);
        chk("d6_done", done, 1); chk("d6_cnt", mismatch_cnt, 8);

        for (int r = 0; r < 30; r++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 2) == 0) ? a : a ^ (8'($urandom) & 8'($urandom));
            run_sweep(a, b, 8'($urandom) & 8'($urandom));
            step(8 + $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
